// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file: CSR read/write/set/clear, cycle/instret counters,
// trap entry (exception, ECALL, interrupt), MRET, and interrupt arbitration.
module csr_mmode_unit #(
  parameter logic [63:0] RESET_MTVEC = 64'h0000_0000_0000_0100,
  parameter logic [63:0] HART_ID     = 64'd0,
  parameter logic [63:0] MISA_VALUE  = 64'h8000_0000_0014_1101
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [11:0] csr_rw_addr_i,
  input  logic [2:0]  csr_rw_cmd_i,
  input  logic [63:0] csr_rw_data_i,
  input  logic        csr_exception_i,
  input  logic [63:0] csr_xcpt_cause_i,
  input  logic        csr_retire_i,
  input  logic [63:0] csr_pc_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  output logic [63:0] csr_rw_rdata_o,
  output logic        csr_interrupt_o,
  output logic [63:0] csr_interrupt_cause_o,
  output logic [63:0] csr_evec_o,
  output logic        csr_eret_o,
  output logic        csr_illegal_o
);

  localparam int unsigned XLEN = 64;

  // csr_cmd_t encoding
  localparam logic [2:0] CMD_NOPE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_SET   = 3'd2;
  localparam logic [2:0] CMD_CLEAR = 3'd3;
  localparam logic [2:0] CMD_SYS   = 3'd4;
  localparam logic [2:0] CMD_READ  = 3'd5;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [11:0] F12_ECALL = 12'h000;
  localparam logic [11:0] F12_MRET  = 12'h302;

  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(64'h888);

  // architectural state
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic            msip_q, mtip_q, meip_q;

  // combinational decode
  logic [XLEN-1:0] rdata_c, wdata_c, mip_c, pend_c, trap_cause_c, tvec_base_c;
  logic            csr_valid_c, csr_ro_c, csr_op_c, wr_req_c, wr_en_c;
  logic            sys_c, trap_c, mret_c, sys_bad_c;

  assign mip_c = XLEN'({52'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_q, 3'd0});

  // CSR read mux: value before this cycle's update
  always_comb begin
    csr_valid_c = 1'b1;
    csr_ro_c    = 1'b0;
    rdata_c     = '0;
    case (csr_rw_addr_i)
      A_MSTATUS:  rdata_c = XLEN'({51'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0});
      A_MISA:     begin rdata_c = MISA_VALUE; csr_ro_c = 1'b1; end
      A_MIE:      rdata_c = mie_q;
      A_MTVEC:    rdata_c = mtvec_q;
      A_MSCRATCH: rdata_c = mscratch_q;
      A_MEPC:     rdata_c = mepc_q;
      A_MCAUSE:   rdata_c = mcause_q;
      A_MTVAL:    rdata_c = mtval_q;
      A_MIP:      rdata_c = mip_c;
      A_MCYCLE:   rdata_c = mcycle_q;
      A_MINSTRET: rdata_c = minstret_q;
      A_MHARTID:  begin rdata_c = HART_ID; csr_ro_c = 1'b1; end
      default:    csr_valid_c = 1'b0;
    endcase
  end

  // operand merge and write qualification
  always_comb begin
    wdata_c  = csr_rw_data_i;
    csr_op_c = 1'b0;
    wr_req_c = 1'b0;
    case (csr_rw_cmd_i)
      CMD_READ:  csr_op_c = 1'b1;
      CMD_WRITE: begin csr_op_c = 1'b1; wr_req_c = 1'b1; end
      CMD_SET:   begin csr_op_c = 1'b1; wr_req_c = |csr_rw_data_i; wdata_c = rdata_c | csr_rw_data_i; end
      CMD_CLEAR: begin csr_op_c = 1'b1; wr_req_c = |csr_rw_data_i; wdata_c = rdata_c & ~csr_rw_data_i; end
      default:   ;
    endcase
  end

  assign wr_en_c = wr_req_c & csr_valid_c & ~csr_ro_c & ~csr_exception_i;

  // trap / MRET decode and redirect target
  always_comb begin
    sys_c        = (csr_rw_cmd_i == CMD_SYS);
    trap_c       = csr_exception_i | (sys_c & (csr_rw_addr_i == F12_ECALL));
    mret_c       = sys_c & ~csr_exception_i & (csr_rw_addr_i == F12_MRET);
    sys_bad_c    = sys_c & ~csr_exception_i & (csr_rw_addr_i != F12_ECALL) & (csr_rw_addr_i != F12_MRET);
    trap_cause_c = csr_exception_i ? csr_xcpt_cause_i : XLEN'(64'd11);
    tvec_base_c  = {mtvec_q[XLEN-1:2], 2'b00};
    csr_evec_o   = '0;
    if (trap_c) begin
      if (trap_cause_c[XLEN-1] && (mtvec_q[1:0] == 2'b01))
        csr_evec_o = tvec_base_c + {trap_cause_c[XLEN-3:0], 2'b00};
      else
        csr_evec_o = tvec_base_c;
    end else if (mret_c) begin
      csr_evec_o = mepc_q;
    end
  end

  // interrupt arbitration: MEI > MTI > MSI
  always_comb begin
    pend_c                = mip_c & mie_q;
    csr_interrupt_o       = mstatus_mie_q & (|pend_c);
    csr_interrupt_cause_o = '0;
    if (pend_c[11])     csr_interrupt_cause_o = {1'b1, 59'd0, 4'd11};
    else if (pend_c[7]) csr_interrupt_cause_o = {1'b1, 59'd0, 4'd7};
    else if (pend_c[3]) csr_interrupt_cause_o = {1'b1, 59'd0, 4'd3};
  end

  assign csr_rw_rdata_o = rdata_c;
  assign csr_eret_o     = mret_c;
  assign csr_illegal_o  = (csr_rw_cmd_i != CMD_NOPE) &
                          ((csr_op_c & ~csr_valid_c) | (wr_req_c & csr_valid_c & csr_ro_c) | sys_bad_c);

  // interrupt line sampling
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mtip_q <= 1'b0;
      meip_q <= 1'b0;
    end else begin
      mtip_q <= timer_irq_i;
      meip_q <= ext_irq_i;
    end
  end

  // counters: explicit write overrides increment
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en_c && csr_rw_addr_i == A_MCYCLE) mcycle_q <= wdata_c;
      else                                       mcycle_q <= mcycle_q + XLEN'(1);
      if (wr_en_c && csr_rw_addr_i == A_MINSTRET)     minstret_q <= wdata_c;
      else if (csr_retire_i && !csr_exception_i)       minstret_q <= minstret_q + XLEN'(1);
    end
  end

  // trap/MRET side effects and CSR writes with WARL masking
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      msip_q         <= 1'b0;
    end else if (trap_c) begin
      mepc_q         <= csr_pc_i & ~XLEN'(1);
      mcause_q       <= trap_cause_c;
      mtval_q        <= '0;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_c) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en_c) begin
      case (csr_rw_addr_i)
        A_MSTATUS: begin
          mstatus_mie_q  <= wdata_c[3];
          mstatus_mpie_q <= wdata_c[7];
        end
        A_MIE:      mie_q      <= wdata_c & MIE_MASK;
        A_MTVEC:    mtvec_q    <= {wdata_c[XLEN-1:2], (wdata_c[1] ? 2'b00 : wdata_c[1:0])};
        A_MSCRATCH: mscratch_q <= wdata_c;
        A_MEPC:     mepc_q     <= wdata_c & ~XLEN'(1);
        A_MCAUSE:   mcause_q   <= wdata_c;
        A_MTVAL:    mtval_q    <= wdata_c;
        A_MIP:      msip_q     <= wdata_c[3];
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_mmode_unit.sv
// Directed self-checking bench for csr_mmode_unit.
module tb_csr_mmode_unit;

  localparam logic [2:0] NOPE = 3'd0, WR = 3'd1, SET = 3'd2, CLR = 3'd3, SYS = 3'd4, RD = 3'd5;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] csr_rw_addr_i;
  logic [2:0]  csr_rw_cmd_i;
  logic [63:0] csr_rw_data_i;
  logic        csr_exception_i;
  logic [63:0] csr_xcpt_cause_i;
  logic        csr_retire_i;
  logic [63:0] csr_pc_i;
  logic        timer_irq_i;
  logic        ext_irq_i;
  logic [63:0] csr_rw_rdata_o;
  logic        csr_interrupt_o;
  logic [63:0] csr_interrupt_cause_o;
  logic [63:0] csr_evec_o;
  logic        csr_eret_o;
  logic        csr_illegal_o;

  int checks = 0;
  int errors = 0;

  csr_mmode_unit dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .csr_rw_addr_i(csr_rw_addr_i), .csr_rw_cmd_i(csr_rw_cmd_i), .csr_rw_data_i(csr_rw_data_i),
    .csr_exception_i(csr_exception_i), .csr_xcpt_cause_i(csr_xcpt_cause_i),
    .csr_retire_i(csr_retire_i), .csr_pc_i(csr_pc_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
    .csr_rw_rdata_o(csr_rw_rdata_o), .csr_interrupt_o(csr_interrupt_o),
    .csr_interrupt_cause_o(csr_interrupt_cause_o), .csr_evec_o(csr_evec_o),
    .csr_eret_o(csr_eret_o), .csr_illegal_o(csr_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // apply a command mid-cycle and let combinational outputs settle
  task automatic drive(input logic [2:0] cmd, input logic [11:0] addr, input logic [63:0] data);
    csr_rw_cmd_i  = cmd;
    csr_rw_addr_i = addr;
    csr_rw_data_i = data;
    #1;
  endtask

  // advance one clock; inputs change again on the falling edge
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    csr_exception_i = 1'b0; csr_xcpt_cause_i = '0; csr_retire_i = 1'b0; csr_pc_i = '0;
    timer_irq_i = 1'b0; ext_irq_i = 1'b0;
    drive(NOPE, 12'h0, 64'h0);
    step(); step();
    rstn_i = 1'b1;
    drive(RD, 12'h305, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h100) begin errors++; $display("FAIL reset_mtvec got %h exp %h", csr_rw_rdata_o, 64'h100); end
    drive(RD, 12'h300, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", csr_rw_rdata_o, 64'h1800); end
    checks++; if (csr_interrupt_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", csr_interrupt_o); end
    checks++; if ({csr_eret_o, csr_illegal_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {csr_eret_o, csr_illegal_o}); end
    checks++; if (csr_evec_o !== 64'h0) begin errors++; $display("FAIL reset_evec got %h exp 0", csr_evec_o); end
  endtask

  task automatic test_rw_set();
    drive(WR, 12'h340, 64'hDEAD);
    checks++; if (csr_rw_rdata_o !== 64'h0) begin errors++; $display("FAIL write_old got %h exp 0", csr_rw_rdata_o); end
    step();
    drive(SET, 12'h340, 64'h0F0);
    checks++; if (csr_rw_rdata_o !== 64'hDEAD) begin errors++; $display("FAIL set_old got %h exp %h", csr_rw_rdata_o, 64'hDEAD); end
    step();
    drive(CLR, 12'h340, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'hDEFD) begin errors++; $display("FAIL set_new got %h exp %h", csr_rw_rdata_o, 64'hDEFD); end
    step();
    drive(RD, 12'h340, 64'hFFFF);
    checks++; if (csr_rw_rdata_o !== 64'hDEFD) begin errors++; $display("FAIL clear0_nowrite got %h exp %h", csr_rw_rdata_o, 64'hDEFD); end
    step();
  endtask

  task automatic test_ecall();
    drive(WR, 12'h305, 64'h200); step();
    drive(WR, 12'h300, 64'h8);   step();
    drive(RD, 12'h300, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h1808) begin errors++; $display("FAIL mstatus_mie got %h exp %h", csr_rw_rdata_o, 64'h1808); end
    csr_pc_i = 64'h8000;
    drive(SYS, 12'h000, 64'h0);
    checks++; if (csr_evec_o !== 64'h200) begin errors++; $display("FAIL ecall_evec got %h exp %h", csr_evec_o, 64'h200); end
    checks++; if ({csr_eret_o, csr_illegal_o} !== 2'b00) begin errors++; $display("FAIL ecall_flags got %b exp 00", {csr_eret_o, csr_illegal_o}); end
    step();
    drive(RD, 12'h341, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h8000) begin errors++; $display("FAIL ecall_mepc got %h exp %h", csr_rw_rdata_o, 64'h8000); end
    drive(RD, 12'h342, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'd11) begin errors++; $display("FAIL ecall_mcause got %h exp %h", csr_rw_rdata_o, 64'd11); end
    drive(RD, 12'h300, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h1880) begin errors++; $display("FAIL ecall_mstatus got %h exp %h", csr_rw_rdata_o, 64'h1880); end
    checks++; if (csr_evec_o !== 64'h0) begin errors++; $display("FAIL idle_evec got %h exp 0", csr_evec_o); end
  endtask

  task automatic test_mret();
    drive(WR, 12'h341, 64'h8004); step();
    drive(SYS, 12'h302, 64'h0);
    checks++; if (csr_eret_o !== 1'b1) begin errors++; $display("FAIL mret_eret got %b exp 1", csr_eret_o); end
    checks++; if (csr_evec_o !== 64'h8004) begin errors++; $display("FAIL mret_evec got %h exp %h", csr_evec_o, 64'h8004); end
    step();
    drive(RD, 12'h300, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", csr_rw_rdata_o, 64'h1888); end
    checks++; if (csr_eret_o !== 1'b0) begin errors++; $display("FAIL mret_eret_clr got %b exp 0", csr_eret_o); end
  endtask

  task automatic test_irq();
    drive(WR, 12'h304, 64'h880); step();
    drive(WR, 12'h305, 64'h201); step();
    drive(RD, 12'h305, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h201) begin errors++; $display("FAIL mtvec_vec got %h exp %h", csr_rw_rdata_o, 64'h201); end
    timer_irq_i = 1'b1;
    drive(NOPE, 12'h000, 64'h0);
    checks++; if (csr_interrupt_o !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", csr_interrupt_o); end
    step();
    checks++; if (csr_interrupt_o !== 1'b1) begin errors++; $display("FAIL irq_timer got %b exp 1", csr_interrupt_o); end
    checks++; if (csr_interrupt_cause_o !== 64'h8000_0000_0000_0007) begin errors++; $display("FAIL irq_timer_cause got %h exp %h", csr_interrupt_cause_o, 64'h8000_0000_0000_0007); end
    drive(RD, 12'h344, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h80) begin errors++; $display("FAIL mip_mtip got %h exp %h", csr_rw_rdata_o, 64'h80); end
    ext_irq_i = 1'b1;
    step();
    checks++; if (csr_interrupt_cause_o !== 64'h8000_0000_0000_000B) begin errors++; $display("FAIL irq_ext_cause got %h exp %h", csr_interrupt_cause_o, 64'h8000_0000_0000_000B); end
    csr_exception_i = 1'b1; csr_xcpt_cause_i = 64'h8000_0000_0000_000B; csr_pc_i = 64'h9000;
    drive(NOPE, 12'h000, 64'h0);
    checks++; if (csr_evec_o !== 64'h22C) begin errors++; $display("FAIL irq_vec_evec got %h exp %h", csr_evec_o, 64'h22C); end
    step();
    csr_exception_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
    drive(RD, 12'h342, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h8000_0000_0000_000B) begin errors++; $display("FAIL irq_mcause got %h exp %h", csr_rw_rdata_o, 64'h8000_0000_0000_000B); end
    checks++; if (csr_interrupt_o !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", csr_interrupt_o); end
    step();
    drive(WR, 12'h344, 64'hFFF);
    checks++; if (csr_illegal_o !== 1'b0) begin errors++; $display("FAIL mip_write_legal got %b exp 0", csr_illegal_o); end
    step();
    drive(RD, 12'h344, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h8) begin errors++; $display("FAIL mip_ro_bits got %h exp %h", csr_rw_rdata_o, 64'h8); end
  endtask

  task automatic test_counters();
    drive(WR, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF); step();
    drive(RD, 12'hB00, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mcycle_max got %h exp all-ones", csr_rw_rdata_o); end
    step();
    checks++; if (csr_rw_rdata_o !== 64'h0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", csr_rw_rdata_o); end
    drive(WR, 12'hB02, 64'd5); csr_retire_i = 1'b1; step();
    drive(RD, 12'hB02, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'd5) begin errors++; $display("FAIL minstret_write_wins got %h exp 5", csr_rw_rdata_o); end
    step();
    checks++; if (csr_rw_rdata_o !== 64'd6) begin errors++; $display("FAIL minstret_inc got %h exp 6", csr_rw_rdata_o); end
    // exception alongside a write and a retire: trap only
    csr_exception_i = 1'b1; csr_xcpt_cause_i = 64'd2; csr_pc_i = 64'hA001;
    drive(WR, 12'h340, 64'h1234);
    checks++; if (csr_evec_o !== 64'h200) begin errors++; $display("FAIL xcpt_evec got %h exp %h", csr_evec_o, 64'h200); end
    step();
    csr_exception_i = 1'b0; csr_retire_i = 1'b0;
    drive(RD, 12'h340, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'hDEFD) begin errors++; $display("FAIL xcpt_write_suppr got %h exp %h", csr_rw_rdata_o, 64'hDEFD); end
    drive(RD, 12'hB02, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'd6) begin errors++; $display("FAIL xcpt_no_retire got %h exp 6", csr_rw_rdata_o); end
    drive(RD, 12'h341, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'hA000) begin errors++; $display("FAIL xcpt_mepc got %h exp %h", csr_rw_rdata_o, 64'hA000); end
    drive(RD, 12'h342, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'd2) begin errors++; $display("FAIL xcpt_mcause got %h exp 2", csr_rw_rdata_o); end
  endtask

  task automatic test_illegal_warl();
    drive(WR, 12'hF14, 64'd5);
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL hartid_wr_illegal got %b exp 1", csr_illegal_o); end
    checks++; if (csr_rw_rdata_o !== 64'h0) begin errors++; $display("FAIL hartid_val got %h exp 0", csr_rw_rdata_o); end
    step();
    drive(RD, 12'hF14, 64'h0);
    checks++; if ({csr_illegal_o, csr_rw_rdata_o} !== {1'b0, 64'h0}) begin errors++; $display("FAIL hartid_read got %b/%h exp 0/0", csr_illegal_o, csr_rw_rdata_o); end
    drive(WR, 12'h301, 64'h0);
    checks++; if ({csr_illegal_o, csr_rw_rdata_o} !== {1'b1, 64'h8000_0000_0014_1101}) begin errors++; $display("FAIL misa_wr got %b/%h exp 1/%h", csr_illegal_o, csr_rw_rdata_o, 64'h8000_0000_0014_1101); end
    step();
    drive(RD, 12'h301, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h8000_0000_0014_1101) begin errors++; $display("FAIL misa_unchanged got %h", csr_rw_rdata_o); end
    drive(RD, 12'h7C0, 64'h0);
    checks++; if (csr_illegal_o !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b exp 1", csr_illegal_o); end
    drive(NOPE, 12'h7C0, 64'h0);
    checks++; if (csr_illegal_o !== 1'b0) begin errors++; $display("FAIL nope_legal got %b exp 0", csr_illegal_o); end
    drive(SYS, 12'h105, 64'h0);
    checks++; if ({csr_illegal_o, csr_evec_o} !== {1'b1, 64'h0}) begin errors++; $display("FAIL sys_bad got %b/%h exp 1/0", csr_illegal_o, csr_evec_o); end
    step();
    drive(WR, 12'h305, 64'h207); step();
    drive(RD, 12'h305, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h204) begin errors++; $display("FAIL mtvec_warl got %h exp %h", csr_rw_rdata_o, 64'h204); end
    drive(WR, 12'h341, 64'h1235); step();
    drive(RD, 12'h341, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h1234) begin errors++; $display("FAIL mepc_warl got %h exp %h", csr_rw_rdata_o, 64'h1234); end
  endtask

  task automatic test_reset_mid();
    drive(WR, 12'h340, 64'h55);
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    drive(RD, 12'h340, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h0) begin errors++; $display("FAIL midreset_mscratch got %h exp 0", csr_rw_rdata_o); end
    drive(RD, 12'h305, 64'h0);
    checks++; if (csr_rw_rdata_o !== 64'h100) begin errors++; $display("FAIL midreset_mtvec got %h exp %h", csr_rw_rdata_o, 64'h100); end
  endtask

  initial begin
    test_reset();
    test_rw_set();
    test_ecall();
    test_mret();
    test_irq();
    test_counters();
    test_illegal_warl();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
